// File: rtl/serial_stream_ctrl_pkg.sv
// Shared types and helpers for the serial stream controller:
// FSM state encoding, default build constants and a saturating counter step.
package stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TAIL  = 2'd3
  } state_t;

  localparam int SAMPLE_WIDTH_DEF = 4;
  localparam int CNT_WIDTH_DEF    = 16;
  localparam int DET_TAIL_DEF     = 2;

  // Increment that sticks at max instead of wrapping (counters up to 32 bits).
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max);
    return (value >= max) ? max : value + 32'd1;
  endfunction

endpackage

// File: rtl/serial_stream_ctrl_bit_serializer.sv
// Parallel-to-serial shift register with bit index tracking.
// Build option: SERIAL_STREAM_CTRL_LSB_FIRST_EN selects LSB-first output;
// default is MSB first. Load/shift timing is the same in both builds.
module bit_serializer
  import stream_ctrl_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic                    shift_en,
  input  logic [SAMPLE_WIDTH-1:0] data,
  output logic                    ser_bit,
  output logic                    ser_last
);

  localparam int IDX_W = $clog2(SAMPLE_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLE_WIDTH - 1);

  logic [SAMPLE_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]        bit_idx;

  // Load a new sample or advance one bit; shift_en is never asserted on the last bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if (load) begin
      shreg   <= data;
      bit_idx <= '0;
    end else if (shift_en) begin
`ifdef SERIAL_STREAM_CTRL_LSB_FIRST_EN
      shreg   <= {1'b0, shreg[SAMPLE_WIDTH-1:1]};
`else
      shreg   <= {shreg[SAMPLE_WIDTH-2:0], 1'b0};
`endif
      bit_idx <= bit_idx + IDX_W'(1);
    end
  end

`ifdef SERIAL_STREAM_CTRL_LSB_FIRST_EN
  assign ser_bit = shreg[0];
`else
  assign ser_bit = shreg[SAMPLE_WIDTH-1];
`endif
  assign ser_last = (bit_idx == LAST_IDX);

endmodule

// File: rtl/serial_stream_ctrl.sv
// Run controller for the serial detection datapath: accepts parallel samples,
// serializes them through bit_serializer, frames the run and counts detector
// hits including a short tail window for registered detector outputs.
// Build option: SERIAL_STREAM_CTRL_LSB_FIRST_EN (LSB-first serialization).
module serial_stream_ctrl
  import stream_ctrl_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
  parameter int DET_TAIL     = DET_TAIL_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic                    sample_ready,
  output logic                    ser_data,
  output logic                    ser_valid,
  output logic                    ser_last,
  input  logic                    det_in,
  output logic [CNT_WIDTH-1:0]    det_count,
  output logic [CNT_WIDTH-1:0]    sample_count,
  output logic                    busy,
  output logic                    done
);

  localparam int TAIL_W = (DET_TAIL > 1) ? $clog2(DET_TAIL) : 1;
  localparam logic [TAIL_W-1:0] LAST_TAIL = TAIL_W'(DET_TAIL - 1);
  localparam logic [31:0] CNT_MAX =
    (CNT_WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_WIDTH) - 32'd1);

  state_t            state, state_nxt;
  logic              stop_pending;
  logic [TAIL_W-1:0] tail_cnt;
  logic              accept;
  logic              load;
  logic              shift_en;
  logic              ser_bit;
  logic              last_raw;

  bit_serializer #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_ser (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .shift_en (shift_en),
    .data     (sample_data),
    .ser_bit  (ser_bit),
    .ser_last (last_raw)
  );

  // Outputs that follow directly from the state; all are 0 in IDLE.
  assign ser_valid = (state == ST_SHIFT);
  assign ser_data  = ser_valid & ser_bit;
  assign ser_last  = ser_valid & last_raw;
  assign busy      = (state != ST_IDLE);

  // Next-state, handshake and serializer control.
  always_comb begin
    state_nxt    = state;
    sample_ready = 1'b0;
    accept       = 1'b0;
    load         = 1'b0;
    shift_en     = 1'b0;
    done         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        sample_ready = !stop_pending;
        accept       = sample_valid && sample_ready;
        if (accept) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end else if (stop_pending) begin
          state_nxt = ST_TAIL;
        end
      end
      ST_SHIFT: begin
        // Only the last bit may reload, so consecutive samples run with no bubble.
        sample_ready = last_raw && !stop_pending && !stop;
        accept       = sample_valid && sample_ready;
        if (!last_raw) begin
          shift_en = 1'b1;
        end else if (accept) begin
          load = 1'b1;
        end else if (stop_pending || stop) begin
          state_nxt = ST_TAIL;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_TAIL: begin
        if (tail_cnt == LAST_TAIL) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register, stop latch and tail timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      stop_pending <= 1'b0;
      tail_cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == ST_IDLE)
        stop_pending <= 1'b0;
      else if (stop && state != ST_IDLE)
        stop_pending <= 1'b1;
      tail_cnt <= (state == ST_TAIL) ? tail_cnt + TAIL_W'(1) : '0;
    end
  end

  // Run counters: cleared on start, saturating, frozen while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      det_count    <= '0;
      sample_count <= '0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        det_count    <= '0;
        sample_count <= '0;
      end
    end else begin
      if (accept)
        sample_count <= CNT_WIDTH'(sat_inc(32'(sample_count), CNT_MAX));
      if (det_in)
        det_count <= CNT_WIDTH'(sat_inc(32'(det_count), CNT_MAX));
    end
  end

endmodule

// File: tb/tb_serial_stream_ctrl.sv
// Directed bench for serial_stream_ctrl (default MSB-first build, DET_TAIL=2).
module tb_serial_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        sample_valid = 1'b0;
  logic [3:0]  sample_data = 4'h0;
  logic        sample_ready;
  logic        ser_data;
  logic        ser_valid;
  logic        ser_last;
  logic        det_in = 1'b0;
  logic [15:0] det_count;
  logic [15:0] sample_count;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  serial_stream_ctrl #(
    .SAMPLE_WIDTH(4),
    .CNT_WIDTH(16),
    .DET_TAIL(2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .stop         (stop),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .ser_data     (ser_data),
    .ser_valid    (ser_valid),
    .ser_last     (ser_last),
    .det_in       (det_in),
    .det_count    (det_count),
    .sample_count (sample_count),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Move to the next cycle; inputs are driven right after the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before checking.
  task automatic settle();
    @(negedge clk);
  endtask

  // Check one serialized bit in the current cycle.
  task automatic chk_bit(input string tag, input logic b, input logic last, input logic rdy);
    settle();
    chk({tag, "_vld"}, ser_valid, 1'b1);
    chk({tag, "_dat"}, ser_data, b);
    chk({tag, "_last"}, ser_last, last);
    chk({tag, "_rdy"}, sample_ready, rdy);
  endtask

  // Run out a bounded number of cycles, expecting exactly one done and an idle finish.
  task automatic drain(input string tag, input int exp_sv);
    int dones = 0;
    int svs = 0;
    for (int i = 0; i < 8; i++) begin
      settle();
      dones += int'(done);
      svs += int'(ser_valid);
      next_cycle();
    end
    chk({tag, "_done_cnt"}, dones, 1);
    chk({tag, "_sv_cnt"}, svs, exp_sv);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  // Issue start in IDLE and step into WAIT.
  task automatic do_start();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  logic [3:0] pat;

  initial begin
    // Reset state
    #12;
    settle();
    chk("rst_busy", busy, 1'b0);
    chk("rst_sv", ser_valid, 1'b0);
    chk("rst_rdy", sample_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cnt", {det_count, sample_count}, 32'h0);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    // Single sample 1011 with stop during serialization
    do_start();
    sample_valid = 1'b1;
    sample_data = 4'b1011;
    settle();
    chk("s1_wait_rdy", sample_ready, 1'b1);
    chk("s1_wait_busy", busy, 1'b1);
    chk("s1_wait_sv", ser_valid, 1'b0);
    next_cycle();
    sample_valid = 1'b0;
    stop = 1'b1;
    chk_bit("s1_b0", 1'b1, 1'b0, 1'b0);
    next_cycle();
    stop = 1'b0;
    chk_bit("s1_b1", 1'b0, 1'b0, 1'b0);
    next_cycle();
    chk_bit("s1_b2", 1'b1, 1'b0, 1'b0);
    next_cycle();
    chk_bit("s1_b3", 1'b1, 1'b1, 1'b0);
    next_cycle();
    settle();
    chk("s1_t0_sv", ser_valid, 1'b0);
    chk("s1_t0_done", done, 1'b0);
    chk("s1_t0_busy", busy, 1'b1);
    next_cycle();
    settle();
    chk("s1_t1_done", done, 1'b1);
    next_cycle();
    settle();
    chk("s1_idle_done", done, 1'b0);
    chk("s1_idle_busy", busy, 1'b0);
    chk("s1_scnt", sample_count, 16'd1);
    chk("s1_dcnt", det_count, 16'd0);
    next_cycle();

    // Back-to-back 4'hA then 4'h5
    do_start();
    sample_valid = 1'b1;
    sample_data = 4'hA;
    next_cycle();
    sample_data = 4'h5;
    pat = 4'hA;
    for (int i = 0; i < 4; i++) begin
      chk_bit($sformatf("b2b_a%0d", i), pat[3-i], i == 3, i == 3);
      next_cycle();
    end
    sample_valid = 1'b0;
    pat = 4'h5;
    for (int i = 0; i < 4; i++) begin
      chk_bit($sformatf("b2b_b%0d", i), pat[3-i], i == 3, i == 3);
      next_cycle();
    end
    stop = 1'b1;
    start = 1'b1;
    settle();
    chk("b2b_wait_sv", ser_valid, 1'b0);
    next_cycle();
    stop = 1'b0;
    start = 1'b0;
    drain("b2b", 0);
    chk("b2b_scnt", sample_count, 16'd2);

    // Hit counting with a late detector pulse in the tail
    do_start();
    sample_valid = 1'b1;
    sample_data = 4'hF;
    next_cycle();
    sample_valid = 1'b0;
    stop = 1'b1;
    det_in = 1'b1;
    next_cycle();
    stop = 1'b0;
    next_cycle();
    det_in = 1'b0;
    next_cycle();
    det_in = 1'b1;
    next_cycle();
    settle();
    chk("hit_t0_sv", ser_valid, 1'b0);
    next_cycle();
    det_in = 1'b0;
    settle();
    chk("hit_t1_done", done, 1'b1);
    next_cycle();
    det_in = 1'b1;
    settle();
    chk("hit_cnt", det_count, 16'd4);
    next_cycle();
    det_in = 1'b0;
    settle();
    chk("hit_idle_cnt", det_count, 16'd4);
    next_cycle();

    // Stop in WAIT with the source stalled
    do_start();
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
    settle();
    chk("sw_rdy", sample_ready, 1'b0);
    next_cycle();
    drain("sw", 0);
    chk("sw_scnt", sample_count, 16'd0);

    // Stop together with a handshake in WAIT
    do_start();
    sample_valid = 1'b1;
    sample_data = 4'b0110;
    stop = 1'b1;
    settle();
    chk("sh_rdy", sample_ready, 1'b1);
    next_cycle();
    stop = 1'b0;
    sample_data = 4'b1001;
    pat = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      chk_bit($sformatf("sh_b%0d", i), pat[3-i], i == 3, 1'b0);
      next_cycle();
    end
    drain("sh", 0);
    sample_valid = 1'b0;
    chk("sh_scnt", sample_count, 16'd1);

    // Reset asserted on the second serialized bit
    do_start();
    sample_valid = 1'b1;
    sample_data = 4'b1011;
    next_cycle();
    sample_valid = 1'b0;
    next_cycle();
    reset_n = 1'b0;
    #1;
    chk("ar_sv", ser_valid, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_scnt", sample_count, 16'd0);
    chk("ar_data", ser_data, 1'b0);
    begin
      int dones = 0;
      for (int i = 0; i < 4; i++) begin
        settle();
        dones += int'(done);
        next_cycle();
      end
      chk("ar_no_done", dones, 0);
    end
    reset_n = 1'b1;
    next_cycle();
    do_start();
    sample_valid = 1'b1;
    sample_data = 4'b0011;
    next_cycle();
    sample_valid = 1'b0;
    stop = 1'b1;
    pat = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      chk_bit($sformatf("ar2_b%0d", i), pat[3-i], i == 3, 1'b0);
      next_cycle();
      stop = 1'b0;
    end
    drain("ar2", 0);
    chk("ar2_scnt", sample_count, 16'd1);
    chk("ar2_dcnt", det_count, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
